// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types used by the pipeline control blocks.
package cpu_types_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;
endpackage

// File: rtl/dp_types_pkg.sv
// Datapath control types: hazard FSM states and pipeline latch indices.
package dp_types_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} hazard_state_t;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;
endpackage

// File: rtl/raw_detect.sv
// Single source-operand RAW comparator against the EX and MEM writers.
module raw_detect
  import cpu_types_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic     src_used,
  input  regbits_t src,
  input  logic     ex_regWEN,
  input  logic     ex_memREN,
  input  regbits_t ex_rd,
  input  logic     mem_regWEN,
  input  regbits_t mem_rd,
  output logic     raw
);
  logic hit_ex, hit_mem;

  // With forwarding only a load in EX cannot be bypassed in time.
  assign hit_ex  = ex_regWEN && (src == ex_rd) && (FWD_EN ? ex_memREN : 1'b1);
  assign hit_mem = !FWD_EN && mem_regWEN && (src == mem_rd);
  assign raw     = src_used && (src != '0) && (hit_ex || hit_mem);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: PC/latch enables and flushes, wait/halt FSM, stall/flush counters.
module hazard_ctrl
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                dmem_req,
  input  logic                ex_memREN,
  input  logic                ex_regWEN,
  input  logic                mem_regWEN,
  input  regbits_t            ex_rd,
  input  regbits_t            mem_rd,
  input  logic [NSRC*5-1:0]   id_src,
  input  logic [NSRC-1:0]     id_src_used,
  input  logic                mem_mispredict,
  input  logic                wb_halt,
  output logic                pcen,
  output logic [3:0]          stage_en,
  output logic [3:0]          stage_flush,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  hazard_state_t   state;
  logic [NSRC-1:0] raw;
  logic            data_stall, dwait_now, flush_ev, stall_ev;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    raw_detect #(.FWD_EN(FWD_EN)) u_raw (
      .src_used  (id_src_used[i]),
      .src       (id_src[5*i +: 5]),
      .ex_regWEN (ex_regWEN),
      .ex_memREN (ex_memREN),
      .ex_rd     (ex_rd),
      .mem_regWEN(mem_regWEN),
      .mem_rd    (mem_rd),
      .raw       (raw[i])
    );
  end

  assign data_stall = |raw;
  assign dwait_now  = dmem_req && !dhit;

  always_comb begin
    pcen        = 1'b0;
    stage_en    = '0;
    stage_flush = '0;
    flush_ev    = 1'b0;
    if (!nRST || state == HALTED || wb_halt || dwait_now) begin
      // full freeze: everything held, nothing flushed
    end else if (mem_mispredict) begin
      pcen                = 1'b1;
      stage_en            = '1;
      stage_flush[IF_ID]  = 1'b1;
      stage_flush[ID_EX]  = 1'b1;
      stage_flush[EX_MEM] = 1'b1;
      flush_ev            = 1'b1;
    end else if (data_stall) begin
      stage_en            = '1;
      stage_en[IF_ID]     = 1'b0;
      stage_flush[ID_EX]  = 1'b1;
    end else if (!ihit) begin
      stage_en            = '1;
      stage_flush[IF_ID]  = 1'b1;
    end else begin
      pcen                = 1'b1;
      stage_en            = '1;
    end
  end

  assign stall_ev = !pcen && (state != HALTED) && !wb_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN:     if (wb_halt) state <= HALTED;
                 else if (dwait_now) state <= DWAIT;
        DWAIT:   if (wb_halt) state <= HALTED;
                 else if (dhit) state <= RUN;
        default: state <= HALTED;
      endcase
      halted <= (state == HALTED) || wb_halt;
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  logic unused_mem_wb;
  assign unused_mem_wb = stage_en[MEM_WB];
endmodule

// File: tb/tb_hazard_ctrl.sv
// Random + directed bench for hazard_ctrl: forwarding and no-forwarding instances vs. a rule model.
module tb_hazard_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit, dhit, dmem_req, ex_memREN, ex_regWEN, mem_regWEN, mem_mispredict, wb_halt;
  logic [4:0]  ex_rd, mem_rd;
  logic [9:0]  src_a;
  logic [1:0]  used_a;
  logic [14:0] src_b;
  logic [2:0]  used_b;

  logic        pcen_a, pcen_b, halted_a, halted_b;
  logic [3:0]  en_a, fl_a, en_b, fl_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  int n_assert = 0, n_fail = 0;
  int sa, fa, sb, fb;
  bit m_halted;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.NSRC(2), .FWD_EN(1'b1), .CNT_W(16)) dut_a (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .ex_memREN(ex_memREN), .ex_regWEN(ex_regWEN), .mem_regWEN(mem_regWEN),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .id_src(src_a), .id_src_used(used_a),
    .mem_mispredict(mem_mispredict), .wb_halt(wb_halt), .pcen(pcen_a),
    .stage_en(en_a), .stage_flush(fl_a), .halted(halted_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a));

  hazard_ctrl #(.NSRC(3), .FWD_EN(1'b0), .CNT_W(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .ex_memREN(ex_memREN), .ex_regWEN(ex_regWEN), .mem_regWEN(mem_regWEN),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .id_src(src_b), .id_src_used(used_b),
    .mem_mispredict(mem_mispredict), .wb_halt(wb_halt), .pcen(pcen_b),
    .stage_en(en_b), .stage_flush(fl_b), .halted(halted_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {pcen, stage_en, stage_flush} from the priority rules.
  function automatic logic [8:0] exp_ctrl(input int nsrc, input bit fwd,
                                          input logic [14:0] src, input logic [2:0] used);
    bit stall = 0;
    logic [4:0] r;
    for (int k = 0; k < nsrc; k++) begin
      r = src[5*k +: 5];
      if (used[k] && r != 0) begin
        if (ex_regWEN && r == ex_rd && (!fwd || ex_memREN)) stall = 1;
        if (!fwd && mem_regWEN && r == mem_rd) stall = 1;
      end
    end
    if (!nRST || m_halted || wb_halt) return 9'h000;
    if (dmem_req && !dhit)            return 9'h000;
    if (mem_mispredict)               return {1'b1, 4'hF, 4'h7};
    if (stall)                        return {1'b0, 4'hE, 4'h2};
    if (!ihit)                        return {1'b0, 4'hF, 4'h1};
    return {1'b1, 4'hF, 4'h0};
  endfunction

  task automatic check_regs();
    chk("halted_a", 32'(halted_a), 32'(m_halted));
    chk("halted_b", 32'(halted_b), 32'(m_halted));
    chk("stall_a", 32'(stall_a), sa);
    chk("flush_a", 32'(flush_a), fa);
    chk("stall_b", 32'(stall_b), sb);
    chk("flush_b", 32'(flush_b), fb);
  endtask

  // Inputs were driven at a negedge; check comb outputs, clock, update model, check state.
  task automatic tick();
    logic [8:0] ea, eb;
    #2;
    ea = exp_ctrl(2, 1'b1, {5'd0, src_a}, {1'b0, used_a});
    eb = exp_ctrl(3, 1'b0, src_b, used_b);
    chk("ctrl_a", {23'd0, pcen_a, en_a, fl_a}, {23'd0, ea});
    chk("ctrl_b", {23'd0, pcen_b, en_b, fl_b}, {23'd0, eb});
    @(posedge CLK);
    if (nRST) begin
      if (!m_halted && !wb_halt) begin
        if (!ea[8]) sa = (sa < 65535) ? sa + 1 : sa;
        if (!eb[8]) sb = (sb < 15) ? sb + 1 : sb;
        if (!(dmem_req && !dhit) && mem_mispredict) begin
          fa = (fa < 65535) ? fa + 1 : fa;
          fb = (fb < 15) ? fb + 1 : fb;
        end
      end
      if (wb_halt) m_halted = 1;
    end
    #1;
    check_regs();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    sa = 0; fa = 0; sb = 0; fb = 0; m_halted = 0;
    #2;
    chk("rst_ctrl_a", {23'd0, pcen_a, en_a, fl_a}, 32'd0);
    chk("rst_ctrl_b", {23'd0, pcen_b, en_b, fl_b}, 32'd0);
    check_regs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic quiet();
    ihit = 1; dhit = 1; dmem_req = 0; ex_memREN = 0; ex_regWEN = 0; mem_regWEN = 0;
    ex_rd = 0; mem_rd = 0; src_a = 0; used_a = 0; src_b = 0; used_b = 0;
    mem_mispredict = 0; wb_halt = 0;
  endtask

  task automatic rand_inputs();
    ihit = ($urandom % 8) != 0;
    dhit = $urandom % 2;
    dmem_req = ($urandom % 3) == 0;
    ex_memREN = $urandom % 2;
    ex_regWEN = $urandom % 2;
    mem_regWEN = $urandom % 2;
    ex_rd = 5'($urandom_range(0, 3));
    mem_rd = 5'($urandom_range(0, 3));
    for (int k = 0; k < 2; k++) src_a[5*k +: 5] = 5'($urandom_range(0, 3));
    for (int k = 0; k < 3; k++) src_b[5*k +: 5] = 5'($urandom_range(0, 3));
    used_a = 2'($urandom);
    used_b = 3'($urandom);
    mem_mispredict = ($urandom % 6) == 0;
  endtask

  initial begin
    quiet();
    ex_regWEN = 1; ex_memREN = 1; ex_rd = 8; src_a = 10'd8; used_a = 2'b01;
    @(negedge CLK);
    do_reset();

    // load-use with forwarding, then plain ALU producer
    ex_regWEN = 1; ex_memREN = 1; ex_rd = 8; src_a = 10'd8; used_a = 2'b01;
    tick();
    ex_memREN = 0;
    tick();

    // no-forwarding MEM hit on slot 2, unused slot, register 0
    quiet();
    mem_regWEN = 1; mem_rd = 5; src_b = {5'd5, 10'd0}; used_b = 3'b100;
    tick();
    used_b = 3'b000;
    tick();
    used_b = 3'b100; mem_rd = 0;
    tick();
    src_b = 15'd0;
    tick();

    // dmem wait overlapping a mispredict, released by dhit
    quiet();
    dmem_req = 1; dhit = 0; mem_mispredict = 1;
    repeat (3) tick();
    dhit = 1;
    tick();
    quiet();
    tick();

    // fetch miss
    ihit = 0;
    tick();

    // saturation of the 4-bit counter
    quiet();
    do_reset();
    mem_regWEN = 1; mem_rd = 5; src_b = {5'd5, 10'd0}; used_b = 3'b100;
    repeat (20) tick();
    chk("stall_b_sat", 32'(stall_b), 32'd15);

    quiet();
    do_reset();
    repeat (400) begin
      rand_inputs();
      tick();
    end

    // halt is sticky under any inputs until reset
    quiet();
    wb_halt = 1;
    tick();
    wb_halt = 0;
    repeat (6) begin
      rand_inputs();
      tick();
    end
    chk("halted_sticky", 32'(halted_a), 32'd1);
    do_reset();
    quiet();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit; drives PC enable, per-latch enable/flush and pipeline halt.
- Generalised to NSRC source operands per instruction and a forwarding/no-forwarding mode.
- Adds a registered wait/halt state machine and saturating stall/flush counters.
- Sits beside the datapath; all stage control is combinational from current inputs plus registered state.

Parameters:
- NSRC, 2, source register operands checked per ID-stage instruction (1..4).
- FWD_EN, 1, 1 = forwarding present, only load-use stalls; 0 = stall on any RAW against EX/MEM writers.
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dmem_req  in  1  MEM stage holds a load/store.
- ex_memREN  in  1  EX stage instruction is a load.
- ex_regWEN, mem_regWEN  in  1 each  EX/MEM stage writes the register file.
- ex_rd, mem_rd  in  5 each  destination registers (regbits_t).
- id_src  in  NSRC*5  packed ID-stage source registers; slot i at [5i+4:5i].
- id_src_used  in  NSRC  slot i is a real read.
- mem_mispredict  in  1  branch/jump resolved in MEM disagrees with the fetch path.
- wb_halt  in  1  halt instruction in WB.
- pcen  out  1  PC update enable.
- stage_en  out  4  latch enables: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB.
- stage_flush  out  4  latch flushes, same indexing.
- halted  out  1  sticky halt.
- stall_cnt  out  CNT_W  cycles with pcen=0 while RUN/DWAIT.
- flush_cnt  out  CNT_W  mispredict flush events.

Behaviour:
- Reset (nRST=0, async): state=RUN, counters=0. While nRST=0: pcen=0, stage_en=0, stage_flush=0, halted=0.
- FSM states (hazard_state_t):
  - RUN → DWAIT when dmem_req && !dhit.
  - DWAIT → RUN when dhit.
  - RUN/DWAIT → HALTED when wb_halt.
  - HALTED is terminal until reset.
- raw[i] = id_src_used[i] && id_src[i]!=0 && (hit_ex || hit_mem):
  - hit_ex = ex_regWEN && id_src[i]==ex_rd && (FWD_EN ? ex_memREN : 1).
  - hit_mem = !FWD_EN && mem_regWEN && id_src[i]==mem_rd.
  - Register 0 never causes a hazard. data_stall = OR of raw[i].
- Per-cycle control, first matching rule wins:
  1. state==HALTED or wb_halt: pcen=0, stage_en=0, stage_flush=0.
  2. dmem_req && !dhit: pcen=0, stage_en=0, stage_flush=0 (full freeze).
  3. mem_mispredict: pcen=1, stage_en=4'b1111, stage_flush=4'b0111. Overrides data_stall and !ihit.
  4. data_stall: pcen=0, stage_en=4'b1110, stage_flush=4'b0010 (bubble into EX).
  5. !ihit: pcen=0, stage_en=4'b1111, stage_flush=4'b0001 (bubble into ID).
  6. otherwise: pcen=1, stage_en=4'b1111, stage_flush=0.
- halted = (state==HALTED), registered; rises the cycle after wb_halt.
- stall_cnt increments on each clock edge where state!=HALTED, !wb_halt and pcen==0.
- flush_cnt increments on each edge where rule 3 applies.
- Both counters saturate at all-ones and never wrap.
- Simultaneous dmem wait and mispredict: rule 2 wins. Mispredict is re-evaluated when dhit arrives; flush_cnt counts it once, on the releasing edge.
- Reset mid-DWAIT or while HALTED: returns to RUN with counters cleared.

Decomposition:
- dp_types_pkg: hazard_state_t {RUN, DWAIT, HALTED}, stage index constants IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3.
- cpu_types_pkg: regbits_t.
- One sub-module, raw_detect: single-slot comparator with FWD_EN parameter, instantiated NSRC times by generate.

Test Plan:
- Load-use: FWD_EN=1, ex_memREN=1, ex_regWEN=1, ex_rd=8, id_src slot0=8 used, ihit=1 → pcen=0, stage_en=1110, stage_flush=0010, stall_cnt +1. Repeat with ex_memREN=0 → pcen=1, no flush.
- No-forward mode: FWD_EN=0, mem_regWEN=1, mem_rd=5, NSRC=3, slot2=5 used → stall; with slot2 unused or mem_rd=0 → no stall.
- Dmem wait + mispredict: dmem_req=1, dhit=0 for 3 cycles with mem_mispredict=1 → all enables 0 for 3 cycles, state=DWAIT. dhit=1 on cycle 4 → stage_flush=0111, pcen=1, flush_cnt=1, state=RUN.
- Fetch miss: ihit=0, no other hazards → pcen=0, stage_flush=0001, stage_en=1111.
- Halt: wb_halt=1 → all enables 0 that cycle, halted=1 next cycle and sticky under any inputs. nRST pulse → halted=0, counters=0.
- Saturation: CNT_W=4, hold data_stall 20 cycles → stall_cnt stops at 15.
